// File: rtl/turbo_dispatch_pkg.sv
// Shared types and constants for the turbo packet dispatcher.
package turbo_dispatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } dispatch_state_e;

  localparam int DEF_BUS       = 534;
  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_PKT_BEATS = 25;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turbo_pkt_dispatch_rr_pick.sv
// Combinational rotating-priority finder: first set req bit at or after ptr, wrapping.
module rr_pick
  import turbo_dispatch_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = width_of(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [CH_W:0]       w_sum;

  // Doubling req turns the wrap-around search into a plain shift.
  assign w_dbl = {req, req};
  assign w_rot = NUM_CH'(w_dbl >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        w_sum = {1'b0, ptr} + (CH_W+1)'(k);
        idx   = (w_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(w_sum - (CH_W+1)'(NUM_CH))
                                             : CH_W'(w_sum);
      end
    end
  end

endmodule

// File: rtl/turbo_pkt_dispatch.sv
// Packet-atomic valid/ready dispatcher feeding NUM_CH turbo decoder channels.
// Define TRB_DISPATCH_SKIP_BUSY_EN to skip channels that are not ready at lock time.
module turbo_pkt_dispatch
  import turbo_dispatch_pkg::*;
#(
  parameter  int BUS       = DEF_BUS,
  parameter  int NUM_CH    = DEF_NUM_CH,
  parameter  int PKT_BEATS = DEF_PKT_BEATS,
  localparam int CH_W      = width_of(NUM_CH)
) (
  input  logic              clk_bus,
  input  logic              rst_n,
  input  logic [BUS-1:0]    in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BUS-1:0]    ch_data,
  output logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              ch_sop,
  output logic              ch_eop,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy
);

  localparam int              CNT_W     = width_of(PKT_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_BEATS - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  dispatch_state_e r_state, w_state_nxt;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld_p1;
  logic [BUS-1:0]   r_data_p1;
  logic             r_sop_p1;
  logic             r_eop_p1;

  logic             w_found;
  logic [CH_W-1:0]  w_cand;
  logic             w_in_ready;
  logic             w_lock;
  logic             w_accept;
  logic             w_consume;
  logic             w_last;

`ifdef TRB_DISPATCH_SKIP_BUSY_EN
  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req   (ch_ready),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_cand)
  );
`else
  assign w_found = ch_ready[r_ptr];
  assign w_cand  = r_ptr;
`endif

  assign w_last    = (r_cnt == LAST_BEAT);
  assign w_accept  = w_in_ready && in_valid;
  assign w_consume = r_vld_p1 && ch_ready[r_sel];

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_lock      = 1'b0;
    case (r_state)
      IDLE: begin
        // Lock only once the previous packet's last beat has drained.
        if (in_valid && !r_vld_p1 && w_found) begin
          w_lock      = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        w_in_ready = !r_vld_p1 || ch_ready[r_sel];
        if (in_valid && w_in_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lock) begin
        r_sel <= w_cand;
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_last) r_ptr <= (r_sel == LAST_CH) ? '0 : r_sel + CH_W'(1);
      end
    end
  end

  // Stage p1: output register, loads on accept and may consume in the same cycle.
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_sop_p1  <= 1'b0;
      r_eop_p1  <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= in_data;
      r_sop_p1  <= (r_cnt == '0);
      r_eop_p1  <= w_last;
    end else if (w_consume) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign in_ready = w_in_ready;
  assign ch_valid = r_vld_p1 ? (NUM_CH'(1) << r_sel) : '0;
  assign ch_data  = r_data_p1;
  assign ch_sop   = r_sop_p1;
  assign ch_eop   = r_eop_p1;
  assign cur_ch   = r_sel;
  assign busy     = (r_state == XFER) || r_vld_p1;

endmodule
